instruction_fetch_unit: RTL and testbench

- Initiator side of the instruction-memory read interface.
- Owns the program counter, drives the memory address, and captures the combinational read data into an output register.
- Hands instructions to the decode stage over a valid/ready handshake.
- Supports stall, branch/jump redirect with flush, and halt-on-opcode.

---
 rtl/risc_pkg.sv | 31 +++
 rtl/instruction_fetch_unit_if.sv | 32 +++
 rtl/instruction_fetch_unit.sv | 99 +++++++++
 tb/tb_instruction_fetch_unit.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/risc_pkg.sv
// Shared constants and types for the small RISC core: word/address widths,
// opcode field position, the halt opcode and the fetch state encoding.
package risc_pkg;

  localparam int PC_WIDTH     = 8;
  localparam int INSTR_WIDTH  = 16;

  // Opcode field occupies the top nibble of every instruction word.
  localparam int OPCODE_MSB   = 15;
  localparam int OPCODE_LSB   = 12;
  localparam int OPCODE_WIDTH = OPCODE_MSB - OPCODE_LSB + 1;

  localparam logic [OPCODE_WIDTH-1:0] HALT_OPCODE = 4'b1111;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    HALTED
  } fetch_state_t;

  // Extract the opcode field of an instruction word.
  function automatic logic [OPCODE_WIDTH-1:0] opcode_of(input logic [INSTR_WIDTH-1:0] word);
    return word[OPCODE_MSB:OPCODE_LSB];
  endfunction

  // True when the word stops the fetch stream.
  function automatic logic is_halt(input logic [INSTR_WIDTH-1:0] word);
    return opcode_of(word) == HALT_OPCODE;
  endfunction

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Fetch-side bus: combinational instruction-memory read port plus the
// valid/ready hand-off of fetched instructions to the decode stage.
// The master is the fetch unit; the slave is memory + decode.
interface instruction_fetch_unit_if;
  import risc_pkg::*;

  logic [PC_WIDTH-1:0]    imem_addr;
  logic [INSTR_WIDTH-1:0] imem_data;
  logic                   instr_valid;
  logic                   instr_ready;
  logic [INSTR_WIDTH-1:0] instr;
  logic [PC_WIDTH-1:0]    instr_pc;

  modport master (
    output imem_addr,
    input  imem_data,
    output instr_valid,
    input  instr_ready,
    output instr,
    output instr_pc
  );

  modport slave (
    input  imem_addr,
    output imem_data,
    input  instr_valid,
    output instr_ready,
    input  instr,
    input  instr_pc
  );

endinterface

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the program counter, reads instruction memory
// combinationally at pc, registers the word into a one-entry output holding
// register and hands it to decode over valid/ready. Supports stall, redirect
// with flush, and stopping on the halt opcode.
module instruction_fetch_unit
  import risc_pkg::*;
#(
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                redirect_valid,
  input  logic [PC_WIDTH-1:0] redirect_pc,
  output logic                halted,
  output logic                busy,
  instruction_fetch_unit_if.master fetch_bus
);

  fetch_state_t           state;
  logic [PC_WIDTH-1:0]    pc;
  logic                   instr_valid_q;
  logic [INSTR_WIDTH-1:0] instr_q;
  logic [PC_WIDTH-1:0]    instr_pc_q;
  logic                   slot_free;

  // The holding register can take a new word when it is empty or being drained.
  assign slot_free = !instr_valid_q || fetch_bus.instr_ready;

  // Memory is addressed straight from pc; there is no address register.
  assign fetch_bus.imem_addr   = pc;
  assign fetch_bus.instr_valid = instr_valid_q;
  assign fetch_bus.instr       = instr_q;
  assign fetch_bus.instr_pc    = instr_pc_q;

  // Fetch state machine: pc, holding register and registered status flags.
  // NOTE: non-blocking assignments so every register sees pre-edge values of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      pc            <= RESET_PC;
      instr_valid_q <= 1'b0;
      instr_q       <= '0;
      instr_pc_q    <= '0;
      halted        <= 1'b0;
      busy          <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= FETCH;
            pc    <= RESET_PC;
            busy  <= 1'b1;
          end
        end

        FETCH: begin
          if (redirect_valid) begin
            // Flush wins over delivery: the held word is dropped even if accepted now.
            pc            <= redirect_pc;
            instr_valid_q <= 1'b0;
          end else if (slot_free) begin
            instr_q       <= fetch_bus.imem_data;
            instr_pc_q    <= pc;
            instr_valid_q <= 1'b1;
            if (is_halt(fetch_bus.imem_data)) begin
              // Halt word is still delivered; pc stays on it.
              state  <= HALTED;
              halted <= 1'b1;
              busy   <= 1'b0;
            end else begin
              pc <= pc + PC_WIDTH'(1);
            end
          end
        end

        HALTED: begin
          if (redirect_valid) begin
            state         <= FETCH;
            pc            <= redirect_pc;
            instr_valid_q <= 1'b0;
            halted        <= 1'b0;
            busy          <= 1'b1;
          end else if (instr_valid_q && fetch_bus.instr_ready) begin
            instr_valid_q <= 1'b0;
          end
        end

        default: begin
          state         <= IDLE;
          instr_valid_q <= 1'b0;
          halted        <= 1'b0;
          busy          <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: directed scenarios for
// start, stall, redirect, wrap, restart and asynchronous reset, followed by
// a randomized run checked against a program-order stream model.
module tb_instruction_fetch_unit;
  import risc_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       redirect_valid;
  logic [7:0] redirect_pc;
  logic       halted;
  logic       busy;

  instruction_fetch_unit_if bus ();

  // Instruction memory responder: combinational read at imem_addr.
  logic [15:0] mem [0:255];
  assign bus.imem_data = mem[bus.imem_addr];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  instruction_fetch_unit #(.RESET_PC(8'h00)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halted         (halted),
    .busy           (busy),
    .fetch_bus      (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_word(input string tag, input logic [7:0] epc, input logic [15:0] einstr);
    check({tag, "_valid"}, 32'(bus.instr_valid), 32'd1);
    check({tag, "_pc"},    32'(bus.instr_pc),    32'(epc));
    check({tag, "_instr"}, 32'(bus.instr),       32'(einstr));
  endtask

  // Safety net so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  exp_pc;
    logic [7:0]  ppc;
    logic [15:0] pi;
    logic        pv;
    logic        m_done;
    logic        r_ready;
    logic        r_redir;
    logic [7:0]  r_tgt;
    int          accepted;

    rst_n           = 1'b0;
    start           = 1'b0;
    redirect_valid  = 1'b0;
    redirect_pc     = 8'h00;
    bus.instr_ready = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = {4'h4, 4'h0, 8'(i)};
    mem[0] = 16'h1001;
    mem[1] = 16'h2002;
    mem[2] = 16'h3003;
    mem[3] = 16'hF000;

    // Reset state
    #11;
    check("rst_valid",  32'(bus.instr_valid), 32'd0);
    check("rst_instr",  32'(bus.instr),       32'd0);
    check("rst_ipc",    32'(bus.instr_pc),    32'd0);
    check("rst_halted", 32'(halted),          32'd0);
    check("rst_busy",   32'(busy),            32'd0);
    check("rst_addr",   32'(bus.imem_addr),   32'd0);
    #1 rst_n = 1'b1;

    // Start and straight-line fetch to the halt word
    bus.instr_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_busy",  32'(busy),            32'd1);
    check("start_valid", 32'(bus.instr_valid), 32'd0);
    check("start_addr",  32'(bus.imem_addr),   32'd0);
    tick(); exp_word("seq0", 8'h00, 16'h1001);
    tick(); exp_word("seq1", 8'h01, 16'h2002);
    tick(); exp_word("seq2", 8'h02, 16'h3003);
    tick(); exp_word("seq3", 8'h03, 16'hF000);
    check("halt_halted", 32'(halted),          32'd1);
    check("halt_busy",   32'(busy),            32'd0);
    check("halt_addr",   32'(bus.imem_addr),   32'd3);
    tick();
    check("halt_drain",  32'(bus.instr_valid), 32'd0);
    check("halt_addr2",  32'(bus.imem_addr),   32'd3);
    tick();
    check("halt_addr3",  32'(bus.imem_addr),   32'd3);

    // Restart from halt: start ignored, redirect resumes fetching
    start = 1'b1;
    tick();
    start = 1'b0;
    check("ign_start_halted", 32'(halted),          32'd1);
    check("ign_start_busy",   32'(busy),            32'd0);
    check("ign_start_valid",  32'(bus.instr_valid), 32'd0);
    redirect_valid = 1'b1;
    redirect_pc    = 8'h05;
    tick();
    redirect_valid = 1'b0;
    check("restart_halted", 32'(halted),          32'd0);
    check("restart_busy",   32'(busy),            32'd1);
    check("restart_valid",  32'(bus.instr_valid), 32'd0);
    check("restart_addr",   32'(bus.imem_addr),   32'd5);
    tick(); exp_word("restart", 8'h05, 16'h4005);

    // Stall: hold 2002 for three cycles, then 3003 with no gap
    redirect_valid = 1'b1;
    redirect_pc    = 8'h00;
    tick();
    redirect_valid = 1'b0;
    check("rd0_flush", 32'(bus.instr_valid), 32'd0);
    tick(); exp_word("rd0_w0", 8'h00, 16'h1001);
    tick(); exp_word("rd0_w1", 8'h01, 16'h2002);
    bus.instr_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      exp_word("stall", 8'h01, 16'h2002);
      check("stall_addr", 32'(bus.imem_addr), 32'd2);
    end
    bus.instr_ready = 1'b1;
    tick(); exp_word("unstall", 8'h02, 16'h3003);

    // Redirect while stalled flushes the held word
    bus.instr_ready = 1'b0;
    redirect_valid  = 1'b1;
    redirect_pc     = 8'h0A;
    tick();
    redirect_valid  = 1'b0;
    bus.instr_ready = 1'b1;
    check("rdstall_flush", 32'(bus.instr_valid), 32'd0);
    check("rdstall_addr",  32'(bus.imem_addr),   32'h0A);
    tick(); exp_word("rdstall_tgt", 8'h0A, 16'h400A);

    // PC wrap-around
    redirect_valid = 1'b1;
    redirect_pc    = 8'hFE;
    tick();
    redirect_valid = 1'b0;
    check("wrap_flush", 32'(bus.instr_valid), 32'd0);
    tick(); exp_word("wrap_fe", 8'hFE, 16'h40FE);
    tick(); exp_word("wrap_ff", 8'hFF, 16'h40FF);
    tick(); exp_word("wrap_00", 8'h00, 16'h1001);
    tick(); exp_word("wrap_01", 8'h01, 16'h2002);

    // Asynchronous reset mid-operation, half a cycle long
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid",  32'(bus.instr_valid), 32'd0);
    check("arst_halted", 32'(halted),          32'd0);
    check("arst_busy",   32'(busy),            32'd0);
    check("arst_addr",   32'(bus.imem_addr),   32'd0);
    check("arst_instr",  32'(bus.instr),       32'd0);
    #4 rst_n = 1'b1;
    tick();
    check("arst_idle_busy", 32'(busy), 32'd0);

    // Randomized run against a program-order stream model
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    start = 1'b1;
    tick();
    start    = 1'b0;
    exp_pc   = 8'h00;
    m_done   = 1'b0;
    accepted = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      r_ready = ($urandom_range(0, 9) < 7);
      r_redir = ($urandom_range(0, 24) == 0);
      r_tgt   = 8'($urandom);
      bus.instr_ready = r_ready;
      redirect_valid  = r_redir;
      redirect_pc     = r_tgt;
      pv  = bus.instr_valid;
      pi  = bus.instr;
      ppc = bus.instr_pc;
      tick();
      if (r_redir) begin
        exp_pc = r_tgt;
        m_done = 1'b0;
        check("rnd_flush",       32'(bus.instr_valid), 32'd0);
        check("rnd_flush_halt",  32'(halted),          32'd0);
      end else if (pv && r_ready) begin
        check("rnd_order", 32'(ppc), 32'(exp_pc));
        check("rnd_data",  32'(pi),  32'(mem[ppc]));
        accepted++;
        if (pi[15:12] == 4'hF) m_done = 1'b1;
        else exp_pc = 8'(ppc + 8'd1);
      end else if (pv) begin
        check("rnd_hold_valid", 32'(bus.instr_valid), 32'd1);
        check("rnd_hold_instr", 32'(bus.instr),       32'(pi));
        check("rnd_hold_pc",    32'(bus.instr_pc),    32'(ppc));
      end
      if (m_done) begin
        check("rnd_after_halt_valid", 32'(bus.instr_valid), 32'd0);
        check("rnd_after_halt_flag",  32'(halted),          32'd1);
      end else if (bus.instr_valid) begin
        check("rnd_halt_flag", 32'(halted), 32'(bus.instr[15:12] == 4'hF));
      end
      check("rnd_busy", 32'(busy), 32'(!halted));
    end
    redirect_valid = 1'b0;
    check("rnd_progress", 32'(accepted > 100), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
